clock_mode_ctrl: RTL

- Time-keeping and mode controller for the digital clock, on the 50 MHz domain.
- Consumes the 1 Hz single-cycle tick from the frequency divider and gates the divider via div_en.
- Maintains hours/minutes/seconds and runs a RUN/PAUSE/SET mode FSM driven by two debounced keys.
- Outputs feed the display/segment driver: field values plus a per-field blink mask.

---
 rtl/clock_pkg.sv | 35 +++
 rtl/clock_mode_ctrl_if.sv | 28 ++
 rtl/wrap_counter.sv | 34 +++
 rtl/clock_mode_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the digital-clock time-keeping and mode controller.
// Field widths, default wrap limits and the mode state encoding live here.
package clock_pkg;

  localparam int HOUR_W  = 5;
  localparam int MIN_W   = 6;
  localparam int SEC_W   = 6;
  localparam int STATE_W = 3;

  localparam int unsigned HOUR_MAX_DEF = 23;
  localparam int unsigned MIN_MAX_DEF  = 59;
  localparam int unsigned SEC_MAX_DEF  = 59;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN      = 3'd0,
    ST_SET_HOUR = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_SET_SEC  = 3'd3
  } mode_e;

  // Mode key walks the ring RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
  function automatic mode_e next_mode(mode_e s);
    case (s)
      ST_RUN:      return ST_SET_HOUR;
      ST_SET_HOUR: return ST_SET_MIN;
      ST_SET_MIN:  return ST_SET_SEC;
      default:     return ST_RUN;
    endcase
  endfunction

  function automatic logic is_set(mode_e s);
    return (s != ST_RUN);
  endfunction

endpackage

// File: rtl/clock_mode_ctrl_if.sv
// Signal bundle between the clock controller and its surroundings: run/tick/keys
// in, time fields, blink mask, day carry, divider enable and debug state out.
interface clock_mode_ctrl_if;
  import clock_pkg::*;

  logic               run_en;
  logic               tick;
  logic               key_mode;
  logic               key_inc;
  logic               div_en;
  logic [HOUR_W-1:0]  hour;
  logic [MIN_W-1:0]   minute;
  logic [SEC_W-1:0]   second;
  logic [2:0]         blink;
  logic               carry_day;
  logic [STATE_W-1:0] state;

  modport master (
    output run_en, tick, key_mode, key_inc,
    input  div_en, hour, minute, second, blink, carry_day, state
  );

  modport slave (
    input  run_en, tick, key_mode, key_inc,
    output div_en, hour, minute, second, blink, carry_day, state
  );

endinterface

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) up counter with synchronous clear; carry flags the MAX -> 0 step
// so several instances can be chained into a time-of-day counter.
module wrap_counter #(
  parameter int unsigned MAX   = 59,
  parameter int          WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value,
  output logic             carry
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic at_max;

  assign at_max = (value == MAX_V);
  assign carry  = inc & at_max;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= at_max ? '0 : value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Time-keeping and RUN/SET mode controller: keeps hh:mm:ss from the 1 Hz tick,
// lets two keys edit the fields, and drives the divider enable and blink mask.
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned HOUR_MAX = HOUR_MAX_DEF,
  parameter int unsigned MIN_MAX  = MIN_MAX_DEF,
  parameter int unsigned SEC_MAX  = SEC_MAX_DEF
) (
  input  logic             CLK_50,
  input  logic             reset_en,
  clock_mode_ctrl_if.slave bus
);

  localparam logic [HOUR_W-1:0] HOUR_MAX_V = HOUR_W'(HOUR_MAX);
  localparam logic [MIN_W-1:0]  MIN_MAX_V  = MIN_W'(MIN_MAX);
  localparam logic [SEC_W-1:0]  SEC_MAX_V  = SEC_W'(SEC_MAX);

  mode_e             state_q, state_d;
  logic              key_mode_q, key_inc_q;
  logic              press_mode, press_inc;
  logic              blink_phase_q;
  logic              div_en_q;
  logic              carry_day_q;
  logic [2:0]        blink_d;

  logic              run_tick, edit_inc;
  logic              sec_inc, sec_clr, min_inc, hour_inc;
  logic              sec_carry, min_carry, hour_carry;
  logic [HOUR_W-1:0] hour_v;
  logic [MIN_W-1:0]  min_v;
  logic [SEC_W-1:0]  sec_v;

  // Keys are already debounced and synchronous; one press per rising edge.
  assign press_mode = bus.key_mode & ~key_mode_q;
  assign press_inc  = bus.key_inc  & ~key_inc_q;

  always_ff @(posedge CLK_50 or negedge reset_en) begin
    if (!reset_en) begin
      key_mode_q <= 1'b0;
      key_inc_q  <= 1'b0;
    end else begin
      key_mode_q <= bus.key_mode;
      key_inc_q  <= bus.key_inc;
    end
  end

  always_ff @(posedge CLK_50 or negedge reset_en) begin
    if (!reset_en) state_q <= ST_RUN;
    else           state_q <= state_d;
  end

  // A mode press in a SET state swallows a simultaneous inc press.
  assign run_tick = (state_q == ST_RUN) && bus.run_en && bus.tick;
  assign edit_inc = press_inc && !press_mode;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    sec_inc  = 1'b0;
    sec_clr  = 1'b0;
    min_inc  = 1'b0;
    hour_inc = 1'b0;

    if (press_mode) state_d = next_mode(state_q);

    case (state_q)
      ST_RUN: begin
        sec_inc  = run_tick;
        min_inc  = sec_carry;
        hour_inc = min_carry;
      end
      ST_SET_HOUR: hour_inc = edit_inc;
      ST_SET_MIN:  min_inc  = edit_inc;
      ST_SET_SEC:  sec_clr  = edit_inc;
      default: ;
    endcase
  end

  wrap_counter #(.MAX(SEC_MAX), .WIDTH(SEC_W)) u_sec (
    .clk   (CLK_50),
    .rst_n (reset_en),
    .inc   (sec_inc),
    .clr   (sec_clr),
    .value (sec_v),
    .carry (sec_carry)
  );

  wrap_counter #(.MAX(MIN_MAX), .WIDTH(MIN_W)) u_min (
    .clk   (CLK_50),
    .rst_n (reset_en),
    .inc   (min_inc),
    .clr   (1'b0),
    .value (min_v),
    .carry (min_carry)
  );

  wrap_counter #(.MAX(HOUR_MAX), .WIDTH(HOUR_W)) u_hour (
    .clk   (CLK_50),
    .rst_n (reset_en),
    .inc   (hour_inc),
    .clr   (1'b0),
    .value (hour_v),
    .carry (hour_carry)
  );

  // Hour inc in a SET state can also wrap, so only a running rollover counts as a day.
  always_ff @(posedge CLK_50 or negedge reset_en) begin
    if (!reset_en) begin
      carry_day_q   <= 1'b0;
      div_en_q      <= 1'b0;
      blink_phase_q <= 1'b0;
    end else begin
      carry_day_q <= run_tick && hour_carry;
      div_en_q    <= ((state_q == ST_RUN) && bus.run_en) || is_set(state_q);
      if (state_d != state_q)
        blink_phase_q <= 1'b0;
      else if (is_set(state_q) && bus.tick)
        blink_phase_q <= ~blink_phase_q;
    end
  end

  always_comb begin
    blink_d = 3'b000;
    case (state_q)
      ST_SET_HOUR: blink_d[2] = blink_phase_q;
      ST_SET_MIN:  blink_d[1] = blink_phase_q;
      ST_SET_SEC:  blink_d[0] = blink_phase_q;
      default: ;
    endcase
  end

  assign bus.hour      = hour_v;
  assign bus.minute    = min_v;
  assign bus.second    = sec_v;
  assign bus.blink     = blink_d;
  assign bus.carry_day = carry_day_q;
  assign bus.div_en    = div_en_q;
  assign bus.state     = state_q;

  a_hour_range: assert property (@(posedge CLK_50) disable iff (!reset_en)
    hour_v <= HOUR_MAX_V);
  a_min_range: assert property (@(posedge CLK_50) disable iff (!reset_en)
    min_v <= MIN_MAX_V);
  a_sec_range: assert property (@(posedge CLK_50) disable iff (!reset_en)
    sec_v <= SEC_MAX_V);
  a_day_pulse: assert property (@(posedge CLK_50) disable iff (!reset_en)
    carry_day_q |=> !carry_day_q);

endmodule
